// File: rtl/mvm_ctrl_if.sv
// Avalon-style read channel between mvm_ctrl (master) and the memory wrapper (slave).
// One request per line; returned line arrives with readdatavalid.
interface mvm_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 64
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [LINE_W-1:0] mem_readdata;
    logic              mem_readdatavalid;

    modport master (
        output mem_addr,
        output mem_read,
        input  mem_waitrequest,
        input  mem_readdata,
        input  mem_readdatavalid
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        output mem_waitrequest,
        output mem_readdata,
        output mem_readdatavalid
    );
endinterface

// File: rtl/mvm_ctrl.sv
// Minilab1 matrix-vector sequencer: fetches ROWS matrix lines plus one vector line, unpacks
// them byte-wise into the row/vector FIFOs, then streams all FIFOs into the MAC array.
module mvm_ctrl #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    mvm_ctrl_if.master          mem,
    output logic [ROWS:0]       fifo_wren,
    output logic [DATA_W-1:0]   fifo_wdata,
    output logic [ROWS:0]       fifo_rden,
    output logic                mac_en,
    output logic                mac_clr
);

    localparam int unsigned CntLineW = $clog2(ROWS + 1);
    localparam int unsigned CntByteW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned LineBits = COLS * DATA_W;

    localparam logic [CntLineW-1:0] LastLine = CntLineW'(ROWS);
    localparam logic [CntByteW-1:0] LastByte = CntByteW'(COLS - 1);
    localparam logic [ROWS:0]       WrenOne  = (ROWS + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StFill,
        StMacRun,
        StMacDrain,
        StDone
    } state_e;

    state_e                state_q;
    logic [CntLineW-1:0]   line_q;
    logic [CntByteW-1:0]   byte_q;
    logic [LineBits-1:0]   line_data_q;
    logic                  mac_en_q;

    logic                  idle_or_done;

    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);

    // byte_q doubles as the MAC_RUN cycle counter; it is always left at 0 between uses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            line_q      <= '0;
            byte_q      <= '0;
            line_data_q <= '0;
            mac_en_q    <= 1'b0;
        end else begin
            mac_en_q <= fifo_rden[0];
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        line_q  <= '0;
                        byte_q  <= '0;
                        state_q <= StRdReq;
                    end
                end
                StRdReq: begin
                    if (!mem.mem_waitrequest) begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (mem.mem_readdatavalid) begin
                        line_data_q <= mem.mem_readdata;
                        byte_q      <= '0;
                        state_q     <= StFill;
                    end
                end
                StFill: begin
                    if (byte_q == LastByte) begin
                        byte_q <= '0;
                        if (line_q == LastLine) begin
                            state_q <= StMacRun;
                        end else begin
                            line_q  <= line_q + 1'b1;
                            state_q <= StRdReq;
                        end
                    end else begin
                        byte_q <= byte_q + 1'b1;
                    end
                end
                StMacRun: begin
                    if (byte_q == LastByte) begin
                        byte_q  <= '0;
                        state_q <= StMacDrain;
                    end else begin
                        byte_q <= byte_q + 1'b1;
                    end
                end
                StMacDrain: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        busy         = !idle_or_done;
        done         = (state_q == StDone);
        mem.mem_read = (state_q == StRdReq);
        mem.mem_addr = '0;
        fifo_wren    = '0;
        fifo_wdata   = '0;
        fifo_rden    = '0;
        mac_en       = mac_en_q;
        // Gated by rst so a held start during reset cannot pulse the accumulator clear.
        mac_clr      = !rst && idle_or_done && start;
        if (state_q == StRdReq) begin
            mem.mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(line_q);
        end
        if (state_q == StFill) begin
            fifo_wren  = WrenOne << line_q;
            fifo_wdata = line_data_q[int'(byte_q) * DATA_W +: DATA_W];
        end
        if (state_q == StMacRun) begin
            fifo_rden = '1;
        end
    end

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl: a behavioural memory responder feeds each run, per-cycle outputs
// are traced, then checked against a vector table and hand-derived run properties.
module tb_mvm_ctrl;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;
    localparam int LW     = COLS * DATA_W;
    localparam int MAXC   = 160;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, mac_en, mac_clr;
    logic [ROWS:0]       fifo_wren, fifo_rden;
    logic [DATA_W-1:0]   fifo_wdata;

    always #5 clk = ~clk;

    mvm_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LW)) mem ();

    mvm_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .mem(mem),
        .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_rden(fifo_rden),
        .mac_en(mac_en), .mac_clr(mac_clr)
    );

    logic              tr_busy[MAXC], tr_done[MAXC], tr_read[MAXC], tr_wait[MAXC];
    logic              tr_mac_en[MAXC], tr_mac_clr[MAXC];
    logic [ADDR_W-1:0] tr_addr[MAXC];
    logic [ROWS:0]     tr_wren[MAXC], tr_rden[MAXC];
    logic [7:0]        tr_wdata[MAXC];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic        busy, done, rd;
        logic [31:0] addr;
        logic [ROWS:0] wren;
        logic [7:0]  wdata;
        logic [ROWS:0] rden;
        logic        mac_en, mac_clr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] line_data(input int n);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(n * 16 + k + 1);
        return d;
    endfunction

    function automatic logic [63:0] outs_now();
        return {busy, done, mem.mem_read, mem.mem_addr, fifo_wren, fifo_wdata, fifo_rden,
                mac_en, mac_clr};
    endfunction

    // One run: start at cycle 0, memory answers with per-line stall/latency, optional spurious
    // start+readdatavalid at spur_cyc, optional reset pulse at rst_cyc with a late valid after it.
    task automatic run(input int stall_line, input int stall_n, input int lat_line,
                       input int lat_n, input int spur_cyc, input int rst_cyc, input int ncyc);
        int wait_cnt   = 0;
        int acc_line   = 0;
        int stall_left = stall_n;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == spur_cyc);
            rst   = (c == rst_cyc);
            mem.mem_readdatavalid = 1'b0;
            mem.mem_readdata      = '0;
            mem.mem_waitrequest   = 1'b0;
            if (wait_cnt != 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    mem.mem_readdatavalid = 1'b1;
                    mem.mem_readdata      = line_data(acc_line);
                end
            end
            if (c == spur_cyc || (rst_cyc >= 0 && c == rst_cyc + 1)) begin
                mem.mem_readdatavalid = 1'b1;
                mem.mem_readdata      = 64'hdeadbeefcafef00d;
            end
            if (mem.mem_read) begin
                if (int'(mem.mem_addr) == stall_line && stall_left > 0) begin
                    mem.mem_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    acc_line = int'(mem.mem_addr);
                    wait_cnt = (acc_line == lat_line) ? lat_n : 1;
                end
            end
            if (c == rst_cyc) wait_cnt = 0;
            #1;
            tr_busy[c]    = busy;
            tr_done[c]    = done;
            tr_read[c]    = mem.mem_read;
            tr_wait[c]    = mem.mem_waitrequest;
            tr_addr[c]    = mem.mem_addr;
            tr_wren[c]    = fifo_wren;
            tr_wdata[c]   = fifo_wdata;
            tr_rden[c]    = fifo_rden;
            tr_mac_en[c]  = mac_en;
            tr_mac_clr[c] = mac_clr;
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        mem.mem_readdatavalid = 1'b0;
        mem.mem_waitrequest   = 1'b0;
        mem.mem_readdata      = '0;
    endtask

    task automatic check_run(input string name, input int done_cyc, input int ncyc);
        int n_acc = 0, bad_addr = 0, cur = -1, kb = 0, nw = 0, bad_w = 0;
        int rden_first = -1, rden_cnt = 0, mac_first = -1, mac_cnt = 0;
        int done_first = -1, done_cnt = 0, busy_cnt = 0, clr_cnt = 0;
        logic [63:0] ld;
        for (int c = 0; c < ncyc; c++) begin
            if (tr_read[c] && !tr_wait[c]) begin
                if (int'(tr_addr[c]) != n_acc) bad_addr++;
                n_acc++;
                cur = int'(tr_addr[c]);
                kb  = 0;
            end
            if (tr_wren[c] != '0) begin
                nw++;
                ld = line_data(cur);
                if (cur < 0 || tr_wren[c] != ((ROWS + 1)'(1) << cur)) bad_w++;
                if (kb > 7 || tr_wdata[c] != ld[kb*8 +: 8]) bad_w++;
                kb++;
            end
            if (tr_rden[c] != '0) begin
                if (rden_first < 0) rden_first = c;
                if (tr_rden[c] != '1) bad_w++;
                rden_cnt++;
            end
            if (tr_mac_en[c]) begin
                if (mac_first < 0) mac_first = c;
                mac_cnt++;
            end
            if (c >= 1 && tr_done[c]) begin
                if (done_first < 0) done_first = c;
                done_cnt++;
            end
            if (tr_busy[c]) busy_cnt++;
            if (tr_mac_clr[c]) clr_cnt++;
        end
        chk({name, ".addr_count"}, n_acc, 9);
        chk({name, ".addr_order"}, bad_addr, 0);
        chk({name, ".wren_count"}, nw, 72);
        chk({name, ".wren_data"}, bad_w, 0);
        chk({name, ".rden_first"}, rden_first, done_cyc - 9);
        chk({name, ".rden_count"}, rden_cnt, 8);
        chk({name, ".macen_first"}, mac_first, done_cyc - 8);
        chk({name, ".macen_count"}, mac_cnt, 8);
        chk({name, ".done_first"}, done_first, done_cyc);
        chk({name, ".done_held"}, done_cnt, ncyc - done_cyc);
        chk({name, ".busy_count"}, busy_cnt, done_cyc - 1);
        chk({name, ".mac_clr"}, {clr_cnt, 31'd0, tr_mac_clr[0]}, {32'd1, 31'd0, 1'b1});
    endtask

    initial begin
        vec_t v;
        logic [63:0] act, exp;
        int n_wait, bad_stall;

        vecs.push_back('{0,   0, 0, 0, 0, 9'h000, 8'h00, 9'h000, 0, 1});
        vecs.push_back('{1,   1, 0, 1, 0, 9'h000, 8'h00, 9'h000, 0, 0});
        vecs.push_back('{2,   1, 0, 0, 0, 9'h000, 8'h00, 9'h000, 0, 0});
        vecs.push_back('{3,   1, 0, 0, 0, 9'h001, 8'h01, 9'h000, 0, 0});
        vecs.push_back('{6,   1, 0, 0, 0, 9'h001, 8'h04, 9'h000, 0, 0});
        vecs.push_back('{10,  1, 0, 0, 0, 9'h001, 8'h08, 9'h000, 0, 0});
        vecs.push_back('{11,  1, 0, 1, 1, 9'h000, 8'h00, 9'h000, 0, 0});
        vecs.push_back('{14,  1, 0, 0, 0, 9'h002, 8'h12, 9'h000, 0, 0});
        vecs.push_back('{81,  1, 0, 1, 8, 9'h000, 8'h00, 9'h000, 0, 0});
        vecs.push_back('{83,  1, 0, 0, 0, 9'h100, 8'h81, 9'h000, 0, 0});
        vecs.push_back('{90,  1, 0, 0, 0, 9'h100, 8'h88, 9'h000, 0, 0});
        vecs.push_back('{91,  1, 0, 0, 0, 9'h000, 8'h00, 9'h1ff, 0, 0});
        vecs.push_back('{92,  1, 0, 0, 0, 9'h000, 8'h00, 9'h1ff, 1, 0});
        vecs.push_back('{98,  1, 0, 0, 0, 9'h000, 8'h00, 9'h1ff, 1, 0});
        vecs.push_back('{99,  1, 0, 0, 0, 9'h000, 8'h00, 9'h000, 1, 0});
        vecs.push_back('{100, 0, 1, 0, 0, 9'h000, 8'h00, 9'h000, 0, 0});
        vecs.push_back('{110, 0, 1, 0, 0, 9'h000, 8'h00, 9'h000, 0, 0});

        rst   = 1'b1;
        start = 1'b1;
        mem.mem_waitrequest   = 1'b0;
        mem.mem_readdatavalid = 1'b0;
        mem.mem_readdata      = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.outputs", outs_now(), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset.idle", {busy, done, mem.mem_read}, 64'd0);

        // Nominal run from IDLE
        run(-1, 0, -1, 1, -1, -1, 115);
        foreach (vecs[i]) begin
            v   = vecs[i];
            act = {v.rd ? tr_addr[v.cyc] : 32'd0, tr_busy[v.cyc], tr_done[v.cyc],
                   tr_read[v.cyc], tr_wren[v.cyc], (v.wren != 0) ? tr_wdata[v.cyc] : 8'd0,
                   tr_rden[v.cyc], tr_mac_en[v.cyc], tr_mac_clr[v.cyc]};
            exp = {v.addr, v.busy, v.done, v.rd, v.wren, v.wdata, v.rden, v.mac_en, v.mac_clr};
            chk($sformatf("vec.cyc%0d", v.cyc), act, exp);
        end
        check_run("nominal", 100, 115);

        // Backpressure: 3 waitrequest cycles on line 2, 4-cycle read latency on line 5
        run(2, 3, 5, 4, -1, -1, 120);
        chk("bp.done_drop", {tr_done[0], tr_done[1]}, 2'b10);
        check_run("bp", 106, 120);
        n_wait    = 0;
        bad_stall = 0;
        for (int c = 0; c < 119; c++) begin
            if (tr_wait[c]) begin
                n_wait++;
                if (!tr_read[c] || tr_addr[c] != 2 || !tr_read[c+1] || tr_addr[c+1] != 2)
                    bad_stall++;
            end
        end
        chk("bp.wait_cycles", n_wait, 3);
        chk("bp.stall_stable", bad_stall, 0);

        // Spurious start and readdatavalid during FILL of line 0
        run(-1, 0, -1, 1, 6, -1, 115);
        check_run("spurious", 100, 115);

        // Reset mid-FILL on line 4, late readdatavalid the cycle after
        run(-1, 0, -1, 1, -1, 45, 49);
        chk("midrst.in_fill", {tr_wren[45], tr_busy[45]}, {9'h010, 1'b1});
        chk("midrst.outputs", {tr_busy[46], tr_done[46], tr_read[46], tr_addr[46], tr_wren[46],
                               tr_wdata[46], tr_rden[46], tr_mac_en[46], tr_mac_clr[46]}, 64'd0);
        chk("midrst.late_valid", {tr_busy[47], tr_read[47], tr_wren[47], tr_busy[48]}, 64'd0);

        run(-1, 0, -1, 1, -1, -1, 115);
        chk("restart.first_addr", {tr_read[1], tr_addr[1]}, {1'b1, 32'd0});
        check_run("restart", 100, 115);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mvm_ctrl.md
# mvm_ctrl

Sequencer for the Minilab1 matrix-vector datapath. After a start pulse it fetches ROWS matrix rows and one vector line from the memory wrapper, unpacks each 64-bit line byte-by-byte into the row FIFOs and the vector FIFO, then streams all FIFOs into the MAC array for COLS cycles and flags completion. It sits between the top-level KEY/SW glue, the Avalon-style memory wrapper, and the FIFO/MAC datapath.

## Interface
- ROWS, 8, number of matrix rows (A FIFOs / MAC units)
- COLS, 8, elements per line (bytes per memory word)
- DATA_W, 8, element width
- ADDR_W, 32, memory word-address width
- BASE_ADDR, 0, word address of row 0; vector B at BASE_ADDR+ROWS

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE, held until next start or rst
- mem_addr  out  ADDR_W  word address, valid while mem_read
- mem_read  out  1  read request
- mem_waitrequest  in  1  request not accepted this cycle
- mem_readdata  in  COLS*DATA_W  returned line
- mem_readdatavalid  in  1  mem_readdata valid
- fifo_wren  out  ROWS+1  one-hot write enable; bits [ROWS-1:0] = A rows, bit ROWS = B
- fifo_wdata  out  DATA_W  byte being written
- fifo_rden  out  ROWS+1  read enable, all bits driven together
- mac_en  out  1  MAC accumulate enable
- mac_clr  out  1  MAC accumulator clear

## Operation
- States: IDLE, RD_REQ, RD_WAIT, FILL, MAC_RUN, MAC_DRAIN, DONE.
- IDLE/DONE + start: mac_clr=1 that cycle; line counter <= 0; -> RD_REQ. done drops the cycle after start.
- RD_REQ: mem_read=1, mem_addr=BASE_ADDR+line; hold both stable while mem_waitrequest=1; on mem_read && !mem_waitrequest -> RD_WAIT.
- RD_WAIT: on mem_readdatavalid, capture mem_readdata into line register, byte counter <= 0, -> FILL.
- FILL: fifo_wren[line]=1 for COLS consecutive cycles; fifo_wdata = byte k of line register, k=0 first (bits [DATA_W-1:0]). After byte COLS-1: if line==ROWS -> MAC_RUN, else line+1 -> RD_REQ.
- MAC_RUN: fifo_rden all ones for exactly COLS cycles -> MAC_DRAIN.
- mac_en = fifo_rden[0] delayed one cycle (FIFO read latency 1); MAC_DRAIN is one cycle covering the last mac_en, -> DONE.
- mem_readdatavalid outside RD_WAIT is ignored (no capture, no state change).
- start while busy is ignored.
- Line counter width $clog2(ROWS+1); byte/run counter width $clog2(COLS); no wrap beyond terminal counts.
- FIFOs are depth >= COLS; no full/empty inputs are consulted.

## Timing
- Reset: state IDLE; busy, done, mem_read, fifo_wren, fifo_rden, mac_en, mac_clr = 0; mem_addr, fifo_wdata = 0; counters 0.
- rst mid-run: IDLE next cycle, all outputs as above; a late readdatavalid after reset is ignored.
- All outputs decoded from registered state/counters except mac_en (registered) and mac_clr (state==IDLE/DONE && start).
- Per line: 1 + W (waitrequest cycles) + L (RD_WAIT cycles, L>=1) + COLS.
- Start sampled at cycle 0, W=0, L=1, ROWS=COLS=8: lines occupy cycles 1-90; fifo_rden 91-98; mac_en 92-99; done=1 from cycle 100.

## Test plan
- Reset: assert rst 2 cycles with start=1 -> all outputs 0, busy=0, done=0; no mem_read.
- Nominal run, W=0, L=1: mem_addr 0..8 once each; fifo_wren one-hot bit n during line n; fifo_rden cycles 91-98; mac_en 92-99; done rises cycle 100 and holds.
- Byte order: line 0 returns 64'h0807060504030201 -> fifo_wren[0] for 8 cycles with fifo_wdata 01,02,...,08; line 8 data lands only on fifo_wren[8].
- Backpressure: mem_waitrequest=1 for 3 cycles on line 2, L=4 on line 5 -> mem_read/mem_addr=2 stable during stall; done delayed by exactly 3+3=6 cycles versus nominal.
- Spurious inputs: start pulse in FILL and extra readdatavalid in FILL -> no effect; run completes as nominal.
- Reset mid-FILL on line 4, then new start -> outputs 0 next cycle; restart issues mem_addr 0 first, mac_clr=1 on start cycle, completes in 100 cycles.
